// File: rtl/tx_symbol_upsampler.sv
// Transmit symbol-to-sample timing generator: FIFO-buffered I/Q symbols, NCO-timed boundaries, zero-stuffed output.
// Define TX_ZOH_EN to hold the last symbol on non-boundary ticks instead of emitting zeros.
module tx_symbol_upsampler #(
    parameter int DATA_WIDTH = 12,
    parameter int SPS        = 4,
    parameter int NCO_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  sample_tick,
    input  logic [DATA_WIDTH-1:0] sym_I,
    input  logic [DATA_WIDTH-1:0] sym_Q,
    input  logic                  sym_valid,
    output logic                  sym_ready,
    input  logic [NCO_W-1:0]      step_adj,
    output logic [DATA_WIDTH-1:0] dout_I,
    output logic [DATA_WIDTH-1:0] dout_Q,
    output logic                  dout_valid,
    output logic                  sym_start,
    output logic                  underrun,
    output logic [7:0]            underrun_cnt,
    output logic                  busy
);
    // state | meaning
    // IDLE  | no NCO advance, ticks emit zero samples
    // RUN   | NCO advances on ticks, boundaries pop the FIFO
    // DRAIN | NCO advances without popping until the next wrap, then IDLE
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam int NCO_STEP_I = (1 << NCO_W) / SPS;
    localparam logic [NCO_W+1:0] STEP_NOM   = (NCO_W+2)'(NCO_STEP_I);
    localparam logic [NCO_W+1:0] STEP_MAX   = (NCO_W+2)'(2 * NCO_STEP_I);
    localparam logic [NCO_W-1:0] PHASE_INIT = NCO_W'((SPS - 1) * NCO_STEP_I);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    state_t                  state;
    logic [NCO_W-1:0]        nco_phase;
    logic signed [NCO_W+1:0] step_raw;
    logic [NCO_W:0]          step_c;
    logic [NCO_W:0]          phase_sum;
    logic                    wrap;

    logic [DATA_WIDTH-1:0]   mem_i [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count;
    logic                    fifo_full, fifo_empty, wr_en, rd_en;
    logic [DATA_WIDTH-1:0]   hold_i, hold_q;

    // Step is widened by two bits so the sign and the 2*NCO_STEP ceiling both fit before clamping.
    always_comb begin
        step_raw = $signed(STEP_NOM) + $signed({{2{step_adj[NCO_W-1]}}, step_adj});
        if (step_raw < $signed((NCO_W+2)'(1)))
            step_c = (NCO_W+1)'(1);
        else if (step_raw > $signed(STEP_MAX))
            step_c = STEP_MAX[NCO_W:0];
        else
            step_c = step_raw[NCO_W:0];
        phase_sum = {1'b0, nco_phase} + step_c;
        wrap      = phase_sum[NCO_W];
    end

    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign sym_ready  = !fifo_full;
    assign wr_en      = sym_valid && !fifo_full;
    assign rd_en      = (state == S_RUN) && enable && sample_tick && wrap && !fifo_empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_i[wr_ptr] <= sym_I;
            mem_q[wr_ptr] <= sym_Q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef TX_ZOH_EN
    logic [DATA_WIDTH-1:0] last_i, last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_i <= '0;
            last_q <= '0;
        end else if (rd_en) begin
            last_i <= mem_i[rd_ptr];
            last_q <= mem_q[rd_ptr];
        end
    end

    assign hold_i = last_i;
    assign hold_q = last_q;
`else
    assign hold_i = '0;
    assign hold_q = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            nco_phase    <= PHASE_INIT;
            dout_I       <= '0;
            dout_Q       <= '0;
            dout_valid   <= 1'b0;
            sym_start    <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
            busy         <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            sym_start  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable && !fifo_empty) begin
                        state     <= S_RUN;
                        nco_phase <= PHASE_INIT;
                        busy      <= 1'b1;
                    end
                    if (sample_tick) begin
                        dout_valid <= 1'b1;
                        dout_I     <= '0;
                        dout_Q     <= '0;
                    end
                end
                S_RUN: begin
                    if (!enable) begin
                        state <= S_DRAIN;
                    end else if (sample_tick) begin
                        nco_phase  <= phase_sum[NCO_W-1:0];
                        dout_valid <= 1'b1;
                        if (wrap) begin
                            sym_start <= 1'b1;
                            if (!fifo_empty) begin
                                dout_I <= mem_i[rd_ptr];
                                dout_Q <= mem_q[rd_ptr];
                            end else begin
                                dout_I   <= hold_i;
                                dout_Q   <= hold_q;
                                underrun <= 1'b1;
                                if (underrun_cnt != 8'hFF)
                                    underrun_cnt <= underrun_cnt + 8'd1;
                            end
                        end else begin
                            dout_I <= hold_i;
                            dout_Q <= hold_q;
                        end
                    end
                end
                S_DRAIN: begin
                    if (enable) begin
                        state <= S_RUN;
                    end else if (sample_tick) begin
                        nco_phase  <= phase_sum[NCO_W-1:0];
                        dout_valid <= 1'b1;
                        if (wrap) begin
                            dout_I <= '0;
                            dout_Q <= '0;
                            state  <= S_IDLE;
                            busy   <= 1'b0;
                        end else begin
                            dout_I <= hold_i;
                            dout_Q <= hold_q;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_symbol_upsampler.sv
// Self-checking bench for tx_symbol_upsampler: step/clamp vector table plus hand sequences, scoreboard on popped symbols.
module tb_tx_symbol_upsampler;
    logic        clk = 1'b0;
    logic        rst_n, enable, sample_tick, sym_valid;
    logic [11:0] sym_I, sym_Q, dout_I, dout_Q;
    logic [15:0] step_adj;
    logic        sym_ready, dout_valid, sym_start, underrun, busy;
    logic [7:0]  underrun_cnt;

    tx_symbol_upsampler dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_tick(sample_tick),
        .sym_I(sym_I), .sym_Q(sym_Q), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .step_adj(step_adj), .dout_I(dout_I), .dout_Q(dout_Q), .dout_valid(dout_valid),
        .sym_start(sym_start), .underrun(underrun), .underrun_cnt(underrun_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] adj;
        int n_ticks;
        int nb_lo, nb_hi;
        int gap_lo, gap_hi;
    } row_t;

    row_t        rows [8];
    logic [23:0] sb [$];
    int          n_tests = 0, n_fail = 0;
    int          feed_left, seq, nb, gap, min_gap, max_gap;
    bit          feed_cont, chk_data;
    logic        s_dv, s_ss, s_busy, s_ready;
    logic [7:0]  prev_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_stats();
        nb = 0; gap = 0; min_gap = 1 << 30; max_gap = 0;
    endtask

    // One clock: observe outputs at the falling edge, then advance the feeder after the rising edge.
    task automatic cycle();
        logic acc;
        @(negedge clk);
        s_dv = dout_valid; s_ss = sym_start; s_busy = busy; s_ready = sym_ready;
        if (dout_valid) begin
            gap++;
            if (sym_start) begin
                if (nb > 0) begin
                    if (gap < min_gap) min_gap = gap;
                    if (gap > max_gap) max_gap = gap;
                end
                nb++;
                gap = 0;
                if (chk_data) begin
                    if (underrun_cnt != prev_cnt)
                        check("underrun_zero", {8'h0, dout_I, dout_Q}, 32'h0);
                    else if (sb.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL sb_pop: got symbol %0h expected none at %0t", {dout_I, dout_Q}, $time);
                    end else
                        check("sym_data", {8'h0, dout_I, dout_Q}, {8'h0, sb.pop_front()});
                end
            end else if (chk_data)
                check("zero_stuff", {8'h0, dout_I, dout_Q}, 32'h0);
        end
        prev_cnt = underrun_cnt;
        acc = rst_n && sym_valid && sym_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            sb.push_back({sym_I, sym_Q});
            seq++;
            if (!feed_cont && feed_left > 0) feed_left--;
        end
        sym_valid = feed_cont || (feed_left > 0);
        sym_I = 12'(seq);
        sym_Q = 12'(seq) ^ 12'h800;
    endtask

    task automatic tick_n(input int n, input int sp);
        for (int i = 0; i < n; i++) begin
            sample_tick = 1'b1;
            cycle();
            sample_tick = 1'b0;
            for (int j = 1; j < sp; j++) cycle();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; sample_tick = 1'b0; step_adj = '0;
        feed_cont = 1'b0; feed_left = 0; chk_data = 1'b0; sym_valid = 1'b0;
        cycle(); cycle();
        rst_n = 1'b1;
        sb.delete();
        seq = 1;
        cycle();
        clear_stats();
    endtask

    task automatic run_row(input row_t r);
        do_reset();
        step_adj = r.adj;
        feed_cont = 1'b1; chk_data = 1'b1;
        repeat (6) cycle();
        enable = 1'b1;
        cycle(); cycle();
        clear_stats();
        tick_n(r.n_ticks, 1);
        cycle(); cycle();
        check("row_bounds_lo", 32'(nb >= r.nb_lo), 32'h1);
        check("row_bounds_hi", 32'(nb <= r.nb_hi), 32'h1);
        check("row_gap_lo", 32'(min_gap >= r.gap_lo), 32'h1);
        check("row_gap_hi", 32'(max_gap <= r.gap_hi), 32'h1);
        check("row_no_underrun", 32'(underrun_cnt), 32'h0);
        enable = 1'b0; feed_cont = 1'b0;
    endtask

    initial begin
        rows[0] = '{16'sd0,      40,    10,   10,   4, 4};
        rows[1] = '{16'sd164,    10000, 2524, 2526, 3, 4};
        rows[2] = '{16'sd32767,  40,    20,   20,   2, 2};
        rows[3] = '{16'sd16384,  40,    20,   20,   2, 2};
        rows[4] = '{16'sd20000,  40,    20,   20,   2, 2};
        rows[5] = '{-16'sd32768, 300,   0,    0,    0, 99999};
        rows[6] = '{-16'sd20000, 300,   0,    0,    0, 99999};
        rows[7] = '{-16'sd8192,  100,   13,   13,   8, 8};

        rst_n = 1'b0; enable = 1'b0; sample_tick = 1'b0; sym_valid = 1'b0;
        sym_I = '0; sym_Q = '0; step_adj = '0;
        feed_cont = 1'b0; feed_left = 0; chk_data = 1'b0; seq = 1; prev_cnt = '0;
        #3;
        check("rst_dout", {8'h0, dout_I, dout_Q}, 32'h0);
        check("rst_flags", {dout_valid, sym_start, underrun, busy}, 32'h0);
        check("rst_cnt", 32'(underrun_cnt), 32'h0);
        check("rst_ready", 32'(sym_ready), 32'h1);

        // IDLE tick gives a zero sample without a symbol start
        do_reset();
        sample_tick = 1'b1; cycle(); sample_tick = 1'b0; cycle();
        check("idle_dv", 32'(s_dv), 32'h1);
        check("idle_start", {s_ss, s_busy}, 32'h0);

        // 8 symbols, tick every 4 clocks, nominal step
        do_reset();
        feed_left = 8; chk_data = 1'b1;
        repeat (6) cycle();
        enable = 1'b1;
        cycle(); cycle();
        clear_stats();
        sample_tick = 1'b1; cycle();
        check("pre_tick_dv", 32'(s_dv), 32'h0);
        sample_tick = 1'b0; cycle();
        check("lat_dv", 32'(s_dv), 32'h1);
        check("lat_start", 32'(s_ss), 32'h1);
        cycle(); cycle();
        tick_n(31, 4);
        cycle(); cycle();
        check("t1_bounds", 32'(nb), 32'd8);
        check("t1_gap_min", 32'(min_gap), 32'd4);
        check("t1_gap_max", 32'(max_gap), 32'd4);
        check("t1_underrun", 32'(underrun_cnt), 32'h0);
        check("t1_sb_empty", 32'(sb.size()), 32'h0);
        check("t1_busy", 32'(s_busy), 32'h1);

        // FIFO fill to full, then one pop frees a slot
        do_reset();
        feed_left = 6; chk_data = 1'b1;
        repeat (8) cycle();
        check("fill_accepts", 32'(sb.size()), 32'd4);
        check("full_ready", 32'(s_ready), 32'h0);
        enable = 1'b1;
        cycle(); cycle();
        clear_stats();
        sample_tick = 1'b1; cycle(); sample_tick = 1'b0; cycle();
        check("ready_after_pop", 32'(s_ready), 32'h1);
        tick_n(23, 1);
        cycle(); cycle();
        check("fill_bounds", 32'(nb), 32'd6);
        check("fill_sb_empty", 32'(sb.size()), 32'h0);
        check("fill_underrun", 32'(underrun_cnt), 32'h0);

        // Disable mid-symbol: drain to the next wrap, FIFO contents kept
        do_reset();
        feed_left = 4; chk_data = 1'b1;
        repeat (6) cycle();
        enable = 1'b1;
        cycle(); cycle();
        tick_n(6, 1);
        enable = 1'b0;
        cycle();
        tick_n(2, 1);
        sample_tick = 1'b1; cycle();
        check("drain_busy", {s_busy, s_dv, s_ss}, 32'h6);
        sample_tick = 1'b0; cycle();
        check("drain_exit", {s_busy, s_dv, s_ss}, 32'h2);
        check("drain_exit_dout", {8'h0, dout_I, dout_Q}, 32'h0);
        chk_data = 1'b0; feed_left = 6;
        repeat (8) cycle();
        check("drain_fifo_kept", 32'(sb.size()), 32'd4);
        check("drain_refull", 32'(s_ready), 32'h0);

        // Underrun after 2 symbols, then count to saturation
        do_reset();
        feed_left = 2; chk_data = 1'b1;
        repeat (4) cycle();
        enable = 1'b1;
        cycle(); cycle();
        clear_stats();
        tick_n(12, 1);
        cycle();
        check("ur_bounds", 32'(nb), 32'd3);
        check("ur_flag", 32'(underrun), 32'h1);
        check("ur_cnt1", 32'(underrun_cnt), 32'd1);
        tick_n(40, 1);
        cycle();
        check("ur_cnt11", 32'(underrun_cnt), 32'd11);
        chk_data = 1'b0;
        step_adj = 16'h7FFF;
        tick_n(600, 1);
        cycle();
        check("ur_sat", 32'(underrun_cnt), 32'd255);
        check("ur_flag_kept", 32'(underrun), 32'h1);

        for (int r = 0; r < 8; r++) run_row(rows[r]);

        // Asynchronous reset in the middle of a run
        do_reset();
        feed_cont = 1'b1; chk_data = 1'b1;
        repeat (6) cycle();
        enable = 1'b1;
        cycle(); cycle();
        tick_n(10, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_flags", {dout_valid, sym_start, underrun, busy}, 32'h0);
        check("arst_dout", {8'h0, dout_I, dout_Q}, 32'h0);
        check("arst_ready", 32'(sym_ready), 32'h1);
        feed_cont = 1'b0; chk_data = 1'b0; enable = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
